// File: rtl/bus_master_ctrl_if.sv
// Command, bus and response signals of one bus master transaction engine.
// master: the engine's view; slave: the command source, arbiter and bus target together.
interface bus_master_ctrl_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              m_req;
    logic              m_grant;
    logic [ADDR_W-1:0] m_addr;
    logic              m_wr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, m_grant, m_din, rsp_ready,
        output cmd_ready, m_req, m_addr, m_wr, m_dout, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, m_grant, m_din, rsp_ready,
        input  cmd_ready, m_req, m_addr, m_wr, m_dout, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/bus_master_ctrl.sv
// Single-beat bus master: accepts one command, requests the bus, runs the transfer while
// granted and returns a response. Optional grant timeout enabled by BUS_MASTER_TIMEOUT_EN.
module bus_master_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input logic                clk,
    input logic                reset,
    bus_master_ctrl_if.master  bus
);
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {StIdle, StReq, StAddr, StRdata, StResp} state_e;

    state_e              state_q, state_d;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                accept;
    logic                timeout;

    assign accept = (state_q == StIdle) && bus.cmd_valid;

`ifdef BUS_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    assign timeout = (state_q == StReq) && !bus.m_grant && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == StReq && !bus.m_grant) cnt_q <= cnt_q + 1'b1;
            else                                  cnt_q <= '0;
            if (accept)       err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign timeout     = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= bus.cmd_wr;
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
            end
            if (accept && bus.cmd_wr)   rdata_q <= '0;
            else if (state_q == StRdata) rdata_q <= bus.m_din;
            else if (timeout)           rdata_q <= '0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.cmd_valid) state_d = StReq;
            StReq: begin
                if (bus.m_grant)  state_d = StAddr;
                else if (timeout) state_d = StResp;
            end
            // Losing the grant mid-address means the beat never reached the bus; retry it.
            StAddr: begin
                if (!bus.m_grant) state_d = StReq;
                else if (wr_q)    state_d = StResp;
                else              state_d = StRdata;
            end
            StRdata: state_d = StResp;
            StResp:  if (bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.m_req     = 1'b0;
        bus.m_wr      = 1'b0;
        bus.m_addr    = '0;
        bus.m_dout    = '0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:  bus.cmd_ready = 1'b1;
            StReq:   bus.m_req     = 1'b1;
            StAddr: begin
                bus.m_req  = 1'b1;
                bus.m_addr = addr_q;
                bus.m_dout = wdata_q;
                bus.m_wr   = wr_q & bus.m_grant;
            end
            StRdata: bus.m_req     = 1'b1;
            StResp:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
endmodule
